dpram_access_arbiter: RTL and testbench

- Shares one dual_port_memory instance between NUM_REQ requesters.
- Independent round-robin arbitration on the write port and on the read port.
- Registers the winning command onto the memory pins and routes returned read data back to the requester that issued it.
- Blocks same-address read/write collisions and flags read responses that never arrive.

---
 rtl/dpram_arb_pkg.sv | 19 +
 rtl/dpram_access_arbiter_rr_arbiter.sv | 35 +++
 rtl/dpram_access_arbiter.sv | 128 ++++++++++++
 tb/tb_dpram_access_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared defaults and helpers for the dual-port RAM access arbiter.
package dpram_arb_pkg;

   localparam int DEF_NUM_REQ   = 2;
   localparam int DEF_RAM_WIDTH = 64;
   localparam int DEF_ADDR_SIZE = 10;
   localparam int MIN_NUM_REQ   = 2;
   localparam int MAX_NUM_REQ   = 4;

   function automatic bit num_req_legal(input int n);
      return (n >= MIN_NUM_REQ) && (n <= MAX_NUM_REQ);
   endfunction

   // Pointer position just after the given winner, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/dpram_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or above the pointer wins.
module rr_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic          en,
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          found,
   output logic [PW-1:0] winner,
   output logic [PW-1:0] next_ptr
);

   // Search from ptr upward with wrap; pointer only advances on a winner.
   always_comb begin
      logic [PW-1:0] idx;
      idx    = '0;
      gnt    = '0;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            winner   = idx;
            gnt[idx] = 1'b1;
         end
      end
      next_ptr = found ? PW'(rr_next(int'(winner), N)) : ptr;
   end

endmodule

// File: rtl/dpram_access_arbiter.sv
// Shares one dual-port memory between NUM_REQ requesters with independent
// round-robin write and read arbitration and tagged read-data return.
module dpram_access_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int RAM_WIDTH = DEF_RAM_WIDTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           arb_en,
   input  logic [NUM_REQ-1:0]             wr_req,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   wr_addr,
   input  logic [NUM_REQ*RAM_WIDTH-1:0]   wr_data,
   output logic [NUM_REQ-1:0]             wr_gnt,
   input  logic [NUM_REQ-1:0]             rd_req,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   rd_addr,
   output logic [NUM_REQ-1:0]             rd_gnt,
   output logic [RAM_WIDTH-1:0]           rd_data,
   output logic [NUM_REQ-1:0]             rd_valid,
   output logic                           rd_err,
   output logic [RAM_WIDTH-1:0]           mem_data_in,
   output logic [ADDR_SIZE-1:0]           mem_wr_address,
   output logic [ADDR_SIZE-1:0]           mem_rd_address,
   output logic                           mem_write,
   output logic                           mem_wr_en,
   output logic                           mem_read,
   output logic                           mem_rd_en,
   input  logic [RAM_WIDTH-1:0]           mem_data_out,
   input  logic                           mem_data_valid
);

   localparam int PW = $clog2(NUM_REQ);

   if (!num_req_legal(NUM_REQ)) begin : g_bad_num_req
      $error("dpram_access_arbiter: NUM_REQ must be in 2..4");
   end

   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [PW-1:0]        wr_win, rd_win, wr_next, rd_next;
   logic                 wr_found, rd_found;
   logic [NUM_REQ-1:0]   wr_gnt_raw, rd_gnt_raw;
   logic [ADDR_SIZE-1:0] wr_sel_addr, rd_sel_addr;
   logic [RAM_WIDTH-1:0] wr_sel_data;
   logic                 arb_active, collide, rd_accept;
   logic                 p1_v, p2_v;
   logic [PW-1:0]        p1_tag, p2_tag;

   // Grants are combinational, so they are also forced low while reset is held.
   assign arb_active = arb_en & rst_n;

   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_wr_arb (
      .en(arb_active), .req(wr_req), .ptr(wr_ptr),
      .gnt(wr_gnt_raw), .found(wr_found), .winner(wr_win), .next_ptr(wr_next)
   );

   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rd_arb (
      .en(arb_active), .req(rd_req), .ptr(rd_ptr),
      .gnt(rd_gnt_raw), .found(rd_found), .winner(rd_win), .next_ptr(rd_next)
   );

   assign wr_sel_addr = ADDR_SIZE'(wr_addr >> (int'(wr_win) * ADDR_SIZE));
   assign wr_sel_data = RAM_WIDTH'(wr_data >> (int'(wr_win) * RAM_WIDTH));
   assign rd_sel_addr = ADDR_SIZE'(rd_addr >> (int'(rd_win) * ADDR_SIZE));

   // Same-address read/write in one cycle: the write wins, the reader retries.
   assign collide   = wr_found && rd_found && (wr_sel_addr == rd_sel_addr);
   assign rd_accept = rd_found && !collide;

   assign wr_gnt    = wr_gnt_raw;
   assign rd_gnt    = rd_accept ? rd_gnt_raw : '0;
   assign mem_wr_en = mem_write;
   assign mem_rd_en = mem_read;

   // Pointers and the registered memory command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         mem_write      <= 1'b0;
         mem_read       <= 1'b0;
         mem_wr_address <= '0;
         mem_rd_address <= '0;
         mem_data_in    <= '0;
      end else begin
         wr_ptr    <= wr_next;
         mem_write <= wr_found;
         mem_read  <= rd_accept;
         if (rd_accept)
            rd_ptr <= rd_next;
         if (wr_found) begin
            mem_wr_address <= wr_sel_addr;
            mem_data_in    <= wr_sel_data;
         end
         if (rd_accept)
            mem_rd_address <= rd_sel_addr;
      end
   end

   // Two-stage tag pipeline: stage 1 = command on pins, stage 2 = data due back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_v     <= 1'b0;
         p2_v     <= 1'b0;
         p1_tag   <= '0;
         p2_tag   <= '0;
         rd_valid <= '0;
         rd_data  <= '0;
         rd_err   <= 1'b0;
      end else begin
         p1_v     <= rd_accept;
         p1_tag   <= rd_win;
         p2_v     <= p1_v;
         p2_tag   <= p1_tag;
         rd_valid <= '0;
         if (p2_v) begin
            if (mem_data_valid) begin
               rd_valid <= NUM_REQ'(1) << p2_tag;
               rd_data  <= mem_data_out;
            end else begin
               rd_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Bench for dpram_access_arbiter with a behavioural dual-port memory attached.
module tb_dpram_access_arbiter;

   localparam int NR = 2;
   localparam int W  = 64;
   localparam int AW = 10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            arb_en = 1'b0;
   logic [NR-1:0]   wr_req = '0, rd_req = '0;
   logic [NR*AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [NR*W-1:0] wr_data = '0;
   logic [NR-1:0]   wr_gnt, rd_gnt, rd_valid;
   logic [W-1:0]    rd_data, mem_data_in, mem_data_out;
   logic            rd_err;
   logic [AW-1:0]   mem_wr_address, mem_rd_address;
   logic            mem_write, mem_wr_en, mem_read, mem_rd_en, mem_data_valid;
   logic            suppress_valid = 1'b0;
   logic [W-1:0]    ram [0:(1<<AW)-1];

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      int         due;
      int         tag;
      logic [W-1:0] data;
   } rd_exp_t;

   always #5 clk = ~clk;

   dpram_access_arbiter #(.NUM_REQ(NR), .RAM_WIDTH(W), .ADDR_SIZE(AW)) dut (
      .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
      .mem_data_in(mem_data_in), .mem_wr_address(mem_wr_address),
      .mem_rd_address(mem_rd_address), .mem_write(mem_write), .mem_wr_en(mem_wr_en),
      .mem_read(mem_read), .mem_rd_en(mem_rd_en),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
   );

   // Memory: write commits at the edge, read data/valid appear the cycle after.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
         mem_data_out   <= '0;
         mem_data_valid <= 1'b0;
      end else begin
         if (mem_write && mem_wr_en) ram[mem_wr_address] <= mem_data_in;
         mem_data_out   <= ram[mem_rd_address];
         mem_data_valid <= mem_read && mem_rd_en && !suppress_valid;
      end
   end

   task automatic idle_inputs();
      wr_req  = '0;
      rd_req  = '0;
      wr_addr = '0;
      rd_addr = '0;
      wr_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      arb_en = 1'b1;
      suppress_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      arb_en = 1'b1;
      wr_req = 2'b11;
      rd_req = 2'b11;
      wr_addr = {10'd3, 10'd4};
      rd_addr = {10'd6, 10'd7};
      #1;
      vec_cnt++;
      if ({wr_gnt, rd_gnt, rd_valid, rd_err, mem_write, mem_wr_en, mem_read, mem_rd_en} !== 11'b0) begin
         err_cnt++;
         $display("FAIL reset_ctrl: got %b expected 0",
                  {wr_gnt, rd_gnt, rd_valid, rd_err, mem_write, mem_wr_en, mem_read, mem_rd_en});
      end
      vec_cnt++;
      if ({mem_wr_address, mem_rd_address, mem_data_in, rd_data} !== '0) begin
         err_cnt++;
         $display("FAIL reset_data: wa=%h ra=%h din=%h rdata=%h expected 0",
                  mem_wr_address, mem_rd_address, mem_data_in, rd_data);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      do_reset();
      wr_req = 2'b01;
      wr_addr[0 +: AW] = 10'd10;
      wr_data[0 +: W] = 64'hDEAD_BEEF_CAFE_BABE;
      #1;
      vec_cnt++;
      if (wr_gnt !== 2'b01 || rd_gnt !== 2'b00) begin
         err_cnt++;
         $display("FAIL wr_grant: wr_gnt=%b rd_gnt=%b expected 01 00", wr_gnt, rd_gnt);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      vec_cnt++;
      if (mem_write !== 1'b1 || mem_wr_en !== 1'b1 || mem_wr_address !== 10'd10 ||
          mem_data_in !== 64'hDEAD_BEEF_CAFE_BABE) begin
         err_cnt++;
         $display("FAIL wr_pins: we=%b en=%b addr=%0d data=%h expected 1 1 10 deadbeefcafebabe",
                  mem_write, mem_wr_en, mem_wr_address, mem_data_in);
      end
      @(negedge clk);
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 10'd10;
      #1;
      vec_cnt++;
      if (rd_gnt !== 2'b01) begin
         err_cnt++;
         $display("FAIL rd_grant: got %b expected 01", rd_gnt);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         if (k == 1) begin
            vec_cnt++;
            if (mem_read !== 1'b1 || mem_rd_en !== 1'b1 || mem_rd_address !== 10'd10) begin
               err_cnt++;
               $display("FAIL rd_pins: rd=%b en=%b addr=%0d expected 1 1 10",
                        mem_read, mem_rd_en, mem_rd_address);
            end
         end
         vec_cnt++;
         if (rd_valid !== ((k == 3) ? 2'b01 : 2'b00)) begin
            err_cnt++;
            $display("FAIL rd_latency: cycle +%0d rd_valid=%b expected %b",
                     k, rd_valid, (k == 3) ? 2'b01 : 2'b00);
         end
         if (k == 3) begin
            vec_cnt++;
            if (rd_data !== 64'hDEAD_BEEF_CAFE_BABE) begin
               err_cnt++;
               $display("FAIL rd_data: got %h expected deadbeefcafebabe", rd_data);
            end
         end
      end
   endtask

   task automatic test_fairness();
      logic [AW-1:0] prev_addr;
      logic [NR-1:0] exp_g;
      do_reset();
      wr_req = 2'b11;
      wr_addr = {10'd200, 10'd100};
      wr_data = {64'h2222, 64'h1111};
      prev_addr = '0;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         vec_cnt++;
         if (wr_gnt !== exp_g) begin
            err_cnt++;
            $display("FAIL fair_gnt: step %0d got %b expected %b", k, wr_gnt, exp_g);
         end
         if (k > 0) begin
            vec_cnt++;
            if (mem_wr_address !== prev_addr) begin
               err_cnt++;
               $display("FAIL fair_addr: step %0d got %0d expected %0d", k, mem_wr_address, prev_addr);
            end
         end
         prev_addr = (k % 2 == 0) ? 10'd100 : 10'd200;
         @(negedge clk);
      end
      idle_inputs();
      #1;
      vec_cnt++;
      if (mem_wr_address !== 10'd200 || mem_data_in !== 64'h2222) begin
         err_cnt++;
         $display("FAIL fair_last: addr=%0d data=%h expected 200 2222", mem_wr_address, mem_data_in);
      end
   endtask

   task automatic test_collision();
      do_reset();
      wr_req = 2'b10;
      wr_addr[AW +: AW] = 10'd5;
      wr_data[W +: W] = 64'h0123_4567_89AB_CDEF;
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 10'd5;
      #1;
      vec_cnt++;
      if (wr_gnt !== 2'b10 || rd_gnt !== 2'b00) begin
         err_cnt++;
         $display("FAIL collide_block: wr_gnt=%b rd_gnt=%b expected 10 00", wr_gnt, rd_gnt);
      end
      @(negedge clk);
      wr_req = 2'b00;
      rd_req = 2'b11;
      rd_addr[AW +: AW] = 10'd7;
      #1;
      vec_cnt++;
      if (rd_gnt !== 2'b01) begin
         err_cnt++;
         $display("FAIL collide_retry: rd_gnt=%b expected 01", rd_gnt);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      #1;
      vec_cnt++;
      if (rd_valid !== 2'b01 || rd_data !== 64'h0123_4567_89AB_CDEF) begin
         err_cnt++;
         $display("FAIL collide_data: rd_valid=%b data=%h expected 01 0123456789abcdef", rd_valid, rd_data);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      wr_req = 2'b01;
      wr_addr[0 +: AW] = 10'd1;
      wr_data[0 +: W] = 64'hAAAA_0000_0000_0001;
      @(negedge clk);
      wr_req = 2'b10;
      wr_addr[AW +: AW] = 10'd2;
      wr_data[W +: W] = 64'hBBBB_0000_0000_0002;
      @(negedge clk);
      idle_inputs();
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 10'd1;
      #1;
      vec_cnt++;
      if (rd_gnt !== 2'b01) begin
         err_cnt++;
         $display("FAIL b2b_gnt0: got %b expected 01", rd_gnt);
      end
      @(negedge clk);
      rd_req = 2'b10;
      rd_addr[AW +: AW] = 10'd2;
      #1;
      vec_cnt++;
      if (rd_gnt !== 2'b10) begin
         err_cnt++;
         $display("FAIL b2b_gnt1: got %b expected 10", rd_gnt);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      #1;
      vec_cnt++;
      if (rd_valid !== 2'b01 || rd_data !== 64'hAAAA_0000_0000_0001) begin
         err_cnt++;
         $display("FAIL b2b_ret0: rd_valid=%b data=%h expected 01 aaaa000000000001", rd_valid, rd_data);
      end
      @(negedge clk);
      #1;
      vec_cnt++;
      if (rd_valid !== 2'b10 || rd_data !== 64'hBBBB_0000_0000_0002) begin
         err_cnt++;
         $display("FAIL b2b_ret1: rd_valid=%b data=%h expected 10 bbbb000000000002", rd_valid, rd_data);
      end
   endtask

   task automatic test_missing_response();
      do_reset();
      suppress_valid = 1'b1;
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 10'd3;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      suppress_valid = 1'b0;
      @(negedge clk);
      #1;
      vec_cnt++;
      if (rd_valid !== 2'b00 || rd_err !== 1'b1) begin
         err_cnt++;
         $display("FAIL missing_resp: rd_valid=%b rd_err=%b expected 00 1", rd_valid, rd_err);
      end
      rd_req = 2'b10;
      rd_addr[AW +: AW] = 10'd3;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      #1;
      vec_cnt++;
      if (rd_valid !== 2'b10 || rd_err !== 1'b1) begin
         err_cnt++;
         $display("FAIL err_sticky: rd_valid=%b rd_err=%b expected 10 1", rd_valid, rd_err);
      end
      do_reset();
      #1;
      vec_cnt++;
      if (rd_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL err_clear: rd_err=%b expected 0", rd_err);
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 10'd4;
      #1;
      vec_cnt++;
      if (rd_gnt !== 2'b01) begin
         err_cnt++;
         $display("FAIL midrst_gnt: got %b expected 01", rd_gnt);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({wr_gnt, rd_gnt, rd_valid, rd_err, mem_write, mem_read, mem_rd_en, mem_rd_address} !== '0) begin
         err_cnt++;
         $display("FAIL midrst_out: gnt=%b/%b rv=%b err=%b rd=%b en=%b addr=%0d expected 0",
                  wr_gnt, rd_gnt, rd_valid, rd_err, mem_read, mem_rd_en, mem_rd_address);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         #1;
         vec_cnt++;
         if (rd_valid !== 2'b00) begin
            err_cnt++;
            $display("FAIL midrst_stale: cycle %0d rd_valid=%b expected 00", k, rd_valid);
         end
         @(negedge clk);
      end
      rd_req = 2'b11;
      wr_req = 2'b11;
      rd_addr = {10'd9, 10'd8};
      wr_addr = {10'd21, 10'd20};
      #1;
      vec_cnt++;
      if (rd_gnt !== 2'b01 || wr_gnt !== 2'b01) begin
         err_cnt++;
         $display("FAIL midrst_ptr: rd_gnt=%b wr_gnt=%b expected 01 01", rd_gnt, wr_gnt);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Random traffic against a cycle-level model of arbitration, memory and return timing.
   task automatic test_random();
      logic [W-1:0]  mm [0:(1<<AW)-1];
      rd_exp_t       q[$];
      rd_exp_t       e;
      int            wp, rp, ew, er, idx;
      logic [NR-1:0] exp_wg, exp_rg, exp_rv;
      logic [W-1:0]  exp_data;
      logic [AW-1:0] wa, ra;
      do_reset();
      for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
      wp = 0;
      rp = 0;
      for (int c = 0; c < 400; c++) begin
         arb_en  = ($urandom_range(0, 7) != 0);
         wr_req  = (c >= 395) ? 2'b00 : NR'($urandom);
         rd_req  = (c >= 395) ? 2'b00 : NR'($urandom);
         wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         wr_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         ew = -1;
         er = -1;
         if (arb_en) begin
            for (int k = 0; k < NR; k++) begin
               idx = (wp + k) % NR;
               if (ew < 0 && ((wr_req >> idx) & 1) != 0) ew = idx;
               idx = (rp + k) % NR;
               if (er < 0 && ((rd_req >> idx) & 1) != 0) er = idx;
            end
         end
         wa = (ew >= 0) ? AW'(wr_addr >> (ew * AW)) : '0;
         ra = (er >= 0) ? AW'(rd_addr >> (er * AW)) : '0;
         if (ew >= 0 && er >= 0 && wa == ra) er = -1;
         exp_wg = (ew >= 0) ? (NR'(1) << ew) : '0;
         exp_rg = (er >= 0) ? (NR'(1) << er) : '0;
         vec_cnt++;
         if (wr_gnt !== exp_wg || rd_gnt !== exp_rg) begin
            err_cnt++;
            $display("FAIL rand_gnt: cycle %0d wr_gnt=%b rd_gnt=%b expected %b %b",
                     c, wr_gnt, rd_gnt, exp_wg, exp_rg);
         end
         exp_rv = '0;
         exp_data = '0;
         if (q.size() > 0 && q[0].due == c) begin
            exp_rv = NR'(1) << q[0].tag;
            exp_data = q[0].data;
            void'(q.pop_front());
         end
         vec_cnt++;
         if (rd_valid !== exp_rv || rd_err !== 1'b0 || (exp_rv != '0 && rd_data !== exp_data)) begin
            err_cnt++;
            $display("FAIL rand_ret: cycle %0d rd_valid=%b err=%b data=%h expected %b 0 %h",
                     c, rd_valid, rd_err, rd_data, exp_rv, exp_data);
         end
         if (er >= 0) begin
            e.due  = c + 3;
            e.tag  = er;
            e.data = mm[ra];
            q.push_back(e);
            rp = (er + 1) % NR;
         end
         if (ew >= 0) begin
            mm[wa] = W'(wr_data >> (ew * W));
            wp = (ew + 1) % NR;
         end
         @(negedge clk);
      end
      vec_cnt++;
      if (q.size() != 0) begin
         err_cnt++;
         $display("FAIL rand_drain: %0d reads outstanding expected 0", q.size());
      end
      idle_inputs();
      arb_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fairness();
      test_collision();
      test_back_to_back();
      test_missing_response();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
